// File: rtl/sd_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sd_link_pkg
//  Description : Shared types and helpers for the sd_link arbiter/framer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sd_link_pkg;

    // Link framer states: idle, header flit, payload flits
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2
    } link_state_e;

    // Number of link flits per requester word
    function automatic int n_part(input int data_width, input int link_width);
        return data_width / link_width;
    endfunction

    // Header flit: requester id, zero-extended (caller truncates to link width)
    function automatic logic [31:0] link_hdr(input logic [31:0] id);
        return id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sd_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sd_rr_arb
//  Description : Combinational round-robin picker. Scans req starting at ptr,
//                wrapping modulo N_REQ; reports first requester found.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_rr_arb #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     gnt_vld,
    output logic [$clog2(N_REQ)-1:0] gnt_id
);

    localparam int IDW = $clog2(N_REQ);

    // Descending scan so the smallest offset from ptr is the last (winning) write
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_link_arb.sv
`default_nettype none
// ============================================================================
//  Module      : sd_link_arb
//  Description : Round-robin arbiter + framer sharing one narrow link among
//                N_REQ wide-word requesters. Packet = id header flit, then
//                the word in LINK_WIDTH flits, least-significant first.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_link_arb
    import sd_link_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int LINK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [DATA_WIDTH-1:0] req_data [N_REQ],
    output logic [N_REQ-1:0]      req_ready,
    output logic                  link_valid,
    output logic [LINK_WIDTH-1:0] link_data,
    input  logic                  link_ready
);

    localparam int N_PART = n_part(DATA_WIDTH, LINK_WIDTH);
    localparam int CW     = $clog2(N_PART);
    localparam int IDW    = $clog2(N_REQ);

    // Parameter legality checks, reported at elaboration
    if (N_REQ < 2) begin : g_chk_nreq
        $error("sd_link_arb: N_REQ must be at least 2");
    end
    if (N_PART < 2 || (N_PART & (N_PART - 1)) != 0) begin : g_chk_npart
        $error("sd_link_arb: DATA_WIDTH/LINK_WIDTH must be a power of two >= 2");
    end
    if (LINK_WIDTH < $clog2(N_REQ)) begin : g_chk_lw
        $error("sd_link_arb: LINK_WIDTH too narrow for requester id");
    end

    link_state_e           rff_state,  rff_state_d;
    logic [IDW-1:0]        rff_gnt_id, rff_gnt_id_d;
    logic [DATA_WIDTH-1:0] rff_buf,    rff_buf_d;
    logic [CW-1:0]         rff_cnt,    rff_cnt_d;
    logic [IDW-1:0]        rff_rr_ptr, rff_rr_ptr_d;

    logic                  win_vld;
    logic [IDW-1:0]        win_id;
    logic                  arb_pt;

    sd_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rff_rr_ptr),
        .gnt_vld (win_vld),
        .gnt_id  (win_id)
    );

    // Next-state, link outputs and grant; grant only at the arbitration point
    always_comb begin
        rff_state_d  = rff_state;
        rff_gnt_id_d = rff_gnt_id;
        rff_buf_d    = rff_buf;
        rff_cnt_d    = rff_cnt;
        rff_rr_ptr_d = rff_rr_ptr;
        req_ready    = '0;
        link_valid   = 1'b0;
        link_data    = rff_buf[LINK_WIDTH-1:0];
        arb_pt       = 1'b0;

        case (rff_state)
            ST_IDLE: begin
                arb_pt = 1'b1;
            end
            ST_HDR: begin
                link_valid = 1'b1;
                link_data  = LINK_WIDTH'(link_hdr(32'(rff_gnt_id)));
                if (link_ready) begin
                    rff_state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                link_valid = 1'b1;
                link_data  = rff_buf[rff_cnt*LINK_WIDTH +: LINK_WIDTH];
                if (link_ready) begin
                    rff_cnt_d = rff_cnt + CW'(1);
                    if (rff_cnt == CW'(N_PART - 1)) begin
                        arb_pt = 1'b1;
                    end
                end
            end
            default: begin
                rff_state_d = ST_IDLE;
            end
        endcase

        // A finishing packet hands straight over to the next winner: no bubble
        if (arb_pt) begin
            rff_cnt_d = '0;
            if (win_vld) begin
                req_ready[win_id] = 1'b1;
                rff_buf_d         = req_data[win_id];
                rff_gnt_id_d      = win_id;
                rff_rr_ptr_d      = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);
                rff_state_d       = ST_HDR;
            end else begin
                rff_state_d = ST_IDLE;
            end
        end

        // No word may be accepted while reset is held
        if (!rstn) begin
            req_ready = '0;
        end
    end

    // Control registers; an in-flight packet is dropped on reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rff_state  <= ST_IDLE;
            rff_cnt    <= '0;
            rff_rr_ptr <= '0;
        end else begin
            rff_state  <= rff_state_d;
            rff_cnt    <= rff_cnt_d;
            rff_rr_ptr <= rff_rr_ptr_d;
        end
    end

    // Datapath registers carry no reset; they are only read after a capture
    always_ff @(posedge clk) begin
        rff_buf    <= rff_buf_d;
        rff_gnt_id <= rff_gnt_id_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_link_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sd_link_arb
//  Description : Directed self-checking bench for sd_link_arb (4 x 64b -> 8b).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_link_arb;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  req_valid;
    logic [63:0] req_data [4];
    logic [3:0]  req_ready;
    logic        link_valid;
    logic [7:0]  link_data;
    logic        link_ready;

    int n_cmp = 0;
    int n_err = 0;

    sd_link_arb #(
        .N_REQ      (4),
        .DATA_WIDTH (64),
        .LINK_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .link_valid (link_valid),
        .link_data  (link_data),
        .link_ready (link_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word for requester i: byte j = 16*i + j + 1
    function automatic logic [63:0] pat_word(input int i);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) w[8*j +: 8] = 8'(16*i + j + 1);
        return w;
    endfunction

    // Flit k of a packet: k=0 header, else payload byte k-1
    function automatic logic [7:0] exp_flit(input int id, input logic [63:0] d, input int k);
        if (k == 0) return 8'(id);
        return d[8*(k-1) +: 8];
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < 4; i++) req_data[i] = pat_word(i);
    endtask

    // One full packet at link_ready=1; the granted requester at the end drops valid
    task automatic pkt(input int id, input logic [63:0] d, input logic [3:0] rdy_end);
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("pkt_valid", link_valid, 1);
            chk("pkt_flit", link_data, exp_flit(id, d, k));
            chk("pkt_req_ready", req_ready, (k == 8) ? rdy_end : 4'b0000);
            tick();
        end
        req_valid = req_valid & ~rdy_end;
    endtask

    initial begin
        logic [63:0] d1;
        logic [3:0]  pat;
        logic [3:0]  exp_rdy;
        int          idx;

        rstn       = 1'b0;
        req_valid  = 4'b0000;
        link_ready = 1'b1;
        load_pattern();
        tick();
        tick();
        #1;
        chk("reset_link_valid", link_valid, 0);
        chk("reset_req_ready", req_ready, 4'b0000);
        rstn = 1'b1;
        tick();

        // Single request from requester 2
        d1          = 64'h0807060504030201;
        req_data[2] = d1;
        req_valid   = 4'b0100;
        #1;
        chk("single_grant", req_ready, 4'b0100);
        chk("single_idle_valid", link_valid, 0);
        tick();
        req_valid = 4'b0000;
        pkt(2, d1, 4'b0000);
        #1;
        chk("single_after_valid", link_valid, 0);
        tick();

        // All requesters busy from a fresh pointer: 0,1,2,3,0 back-to-back
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        load_pattern();
        req_valid = 4'b1111;
        #1;
        chk("busy_first_grant", req_ready, 4'b0001);
        tick();
        for (int c = 0; c < 45; c++) begin
            if (c == 44) req_valid = 4'b0000;
            #1;
            exp_rdy = (c % 9 == 8 && c != 44) ? 4'(1 << ((c / 9 + 1) % 4)) : 4'b0000;
            chk("busy_valid", link_valid, 1);
            chk("busy_flit", link_data, exp_flit((c / 9) % 4, pat_word((c / 9) % 4), c % 9));
            chk("busy_req_ready", req_ready, exp_rdy);
            tick();
        end
        #1;
        chk("busy_end_valid", link_valid, 0);
        tick();

        // Backpressure: link_ready 1,0,0,1,... ; pointer is now 1
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        pat = 4'b1001;
        idx = 0;
        for (int c = 0; c < 40 && idx < 9; c++) begin
            link_ready = pat[c % 4];
            #1;
            chk("bp_valid", link_valid, 1);
            chk("bp_flit", link_data, exp_flit(1, pat_word(1), idx));
            chk("bp_req_ready", req_ready, 4'b0000);
            if (link_ready) idx++;
            tick();
        end
        chk("bp_flits_done", 64'(idx), 64'd9);
        link_ready = 1'b1;
        #1;
        chk("bp_end_valid", link_valid, 0);
        tick();

        // Fairness: 0 granted, then 3 and 1 raise valid mid-packet while 0 re-requests
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("fair_grant0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1011;
        pkt(0, pat_word(0), 4'b0010);
        pkt(1, pat_word(1), 4'b1000);
        pkt(3, pat_word(3), 4'b0001);
        pkt(0, pat_word(0), 4'b0000);
        #1;
        chk("fair_end_valid", link_valid, 0);
        tick();

        // Reset after three payload flits of a packet from requester 2
        req_valid = 4'b0100;
        #1;
        chk("rst_grant2", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rst_pre_flit", link_data, exp_flit(2, pat_word(2), k));
            tick();
        end
        rstn      = 1'b0;
        req_valid = 4'b1001;
        tick();
        #1;
        chk("rst_link_valid", link_valid, 0);
        chk("rst_req_ready", req_ready, 4'b0000);
        rstn = 1'b1;
        #1;
        chk("rst_ptr_grant0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1000;
        pkt(0, pat_word(0), 4'b1000);
        pkt(3, pat_word(3), 4'b0000);
        #1;
        chk("rst_end_valid", link_valid, 0);
        tick();

        // Requester 1 raises then drops valid before it can be granted
        req_valid = 4'b0001;
        #1;
        chk("drop_grant0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0010;
        tick();
        tick();
        req_valid = 4'b0000;
        for (int k = 2; k < 9; k++) tick();
        #1;
        chk("drop_no_hdr", link_valid, 0);
        chk("drop_no_ready", req_ready, 4'b0000);
        tick();
        #1;
        chk("drop_still_idle", link_valid, 0);
        req_valid = 4'b0011;
        #1;
        chk("drop_ptr_kept", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0001;
        pkt(1, pat_word(1), 4'b0001);
        pkt(0, pat_word(0), 4'b0000);
        #1;
        chk("drop_end_valid", link_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
